matmult_sequencer: RTL and testbench

- Initiator side of the dot-product handshake. Snapshots two NxN signed matrices on start and issues one dot-product request per result element, in row-major order, to an external dot_product engine.
- Captures each returned sum into a result matrix, streams each element out with a write strobe, and signals completion.
- Sits between the matmult top level and the dot_product engine. The top level instantiates both.

---
 rtl/matmult_pkg.sv | 24 ++
 rtl/matmult_sequencer.sv | 159 +++++++++++++++
 tb/tb_matmult_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmult_pkg.sv
// matmult_pkg
//   Shared types and defaults for the matrix-multiply sequencer.
//   - seq_state_t : sequencer FSM encoding
//   - N_DEFAULT / TIMEOUT_DEFAULT : default matrix size and WAIT watchdog limit
//   - idx_w()     : width of a row/column counter for an N-wide matrix
package matmult_pkg;

  localparam int N_DEFAULT       = 2;
  localparam int TIMEOUT_DEFAULT = 16;
  localparam int DATA_W          = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // A 1x1 matrix still needs a 1-bit counter.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmult_sequencer.sv
// matmult_sequencer
//   Initiator side of the dot-product handshake. Snapshots A and B on an
//   accepted start, issues one request per element of C in row-major order,
//   stores each returned sum into mat_c and streams it out with res_valid.
//
//   Ports
//     clk, reset          clock, synchronous active-high reset
//     start               new multiplication request (honoured in IDLE only)
//     mat_a, mat_b        operands, captured on accepted start
//     row_vec             current row of captured A      -> engine inp1
//     mat_b_out           captured B                     -> engine inp2
//     column_index        current column                 -> engine column_index
//     enable_product      one-cycle request pulse        -> engine
//     sum, product_done   engine result and result-valid
//     res_valid/row/col/data  one-cycle write strobe of C[res_row][res_col]
//     mat_c               result matrix, held until next accepted start
//     busy, done, err     status; err is sticky (watchdog expiry)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start
//   ISSUE | enable_product pulse for current (row,col), watchdog loaded
//   WAIT  | waiting for product_done or watchdog terminal count
//   DONE  | one-cycle done pulse, start ignored
module matmult_sequencer
  import matmult_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] mat_a [0:N-1][0:N-1],
  input  logic signed [DATA_W-1:0] mat_b [0:N-1][0:N-1],
  output logic signed [DATA_W-1:0] row_vec [0:N-1],
  output logic signed [DATA_W-1:0] mat_b_out [0:N-1][0:N-1],
  output logic        [DATA_W-1:0] column_index,
  output logic                     enable_product,
  input  logic signed [DATA_W-1:0] sum,
  input  logic                     product_done,
  output logic                     res_valid,
  output logic        [DATA_W-1:0] res_row,
  output logic        [DATA_W-1:0] res_col,
  output logic signed [DATA_W-1:0] res_data,
  output logic signed [DATA_W-1:0] mat_c [0:N-1][0:N-1],
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int IW  = idx_w(N);
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [IW-1:0]  LAST    = IW'(N - 1);
  localparam logic [WDW-1:0] WD_LOAD = WDW'(TIMEOUT - 1);

  seq_state_t state, state_nxt;

  logic signed [DATA_W-1:0] a_q [0:N-1][0:N-1];
  logic signed [DATA_W-1:0] b_q [0:N-1][0:N-1];
  logic [IW-1:0]  row, col;
  logic [WDW-1:0] wd_cnt;
  logic           last_elem;
  logic           wd_expired;

  assign last_elem  = (row == LAST) && (col == LAST);
  // Watchdog counts down from TIMEOUT-1, so WAIT lasts at most TIMEOUT cycles.
  assign wd_expired = (wd_cnt == '0);

  // Engine-facing operands are driven straight from the snapshots, so they
  // stay stable across ISSUE and WAIT without extra registers.
  assign row_vec      = a_q[row];
  assign mat_b_out    = b_q;
  assign column_index = DATA_W'(col);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    enable_product = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        enable_product = 1'b1;
        state_nxt      = WAIT;
      end
      WAIT: begin
        // A result arriving on the watchdog's last cycle still counts.
        if (product_done)    state_nxt = last_elem ? DONE : ISSUE;
        else if (wd_expired) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '{default: '{default: '0}};
      b_q       <= '{default: '{default: '0}};
      mat_c     <= '{default: '{default: '0}};
      row       <= '0;
      col       <= '0;
      wd_cnt    <= '0;
      err       <= 1'b0;
      res_valid <= 1'b0;
      res_row   <= '0;
      res_col   <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= mat_a;
            b_q   <= mat_b;
            mat_c <= '{default: '{default: '0}};
            err   <= 1'b0;
            row   <= '0;
            col   <= '0;
          end
        end
        ISSUE: wd_cnt <= WD_LOAD;
        WAIT: begin
          if (product_done) begin
            mat_c[row][col] <= sum;
            res_valid       <= 1'b1;
            res_row         <= DATA_W'(row);
            res_col         <= DATA_W'(col);
            res_data        <= sum;
            if (col != LAST) begin
              col <= col + 1'b1;
            end else if (row != LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end
          end else if (wd_expired) begin
            err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmult_sequencer.sv
// tb_matmult_sequencer
//   Scoreboard bench: each run pushes the expected C elements (from a plain
//   matrix-product model) into a queue; a monitor pops one per res_valid.
//   A behavioural dot-product engine stub answers enable_product after a
//   programmable delay, or never (mute) to exercise the watchdog.
module tb_matmult_sequencer;

  localparam int N       = 2;
  localparam int TIMEOUT = 16;

  logic clk;
  logic reset;
  logic start;
  logic signed [31:0] mat_a [0:N-1][0:N-1];
  logic signed [31:0] mat_b [0:N-1][0:N-1];
  logic signed [31:0] row_vec [0:N-1];
  logic signed [31:0] mat_b_out [0:N-1][0:N-1];
  logic [31:0] column_index;
  logic enable_product;
  logic signed [31:0] sum;
  logic product_done;
  logic res_valid;
  logic [31:0] res_row, res_col;
  logic signed [31:0] res_data;
  logic signed [31:0] mat_c [0:N-1][0:N-1];
  logic busy, done, err;

  matmult_sequencer #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mat_a(mat_a), .mat_b(mat_b),
    .row_vec(row_vec), .mat_b_out(mat_b_out), .column_index(column_index),
    .enable_product(enable_product), .sum(sum), .product_done(product_done),
    .res_valid(res_valid), .res_row(res_row), .res_col(res_col),
    .res_data(res_data), .mat_c(mat_c),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int row;
    int col;
    int data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   en_cnt   = 0;
  int   eng_delay = 1;
  bit   eng_mute  = 1'b0;
  int   ma [0:N-1][0:N-1];
  int   mb [0:N-1][0:N-1];

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference: plain matrix product with 32-bit wrap (int arithmetic).
  function automatic int ref_c(input int i, input int j);
    int acc = 0;
    for (int k = 0; k < N; k++) acc += ma[i][k] * mb[k][j];
    return acc;
  endfunction

  // Engine stub, driven on the falling edge so the DUT samples stable values.
  bit eng_pend = 1'b0;
  int eng_cnt  = 0;
  int eng_val  = 0;
  always @(negedge clk) begin
    product_done = 1'b0;
    if (reset) begin
      eng_pend = 1'b0;
      sum      = '0;
    end else begin
      if (eng_pend) begin
        eng_cnt--;
        if (eng_cnt <= 0) begin
          product_done = 1'b1;
          sum          = eng_val;
          eng_pend     = 1'b0;
        end
      end
      if (enable_product && !eng_mute) begin
        int acc;
        int ci;
        acc = 0;
        ci  = int'(column_index);
        for (int k = 0; k < N; k++)
          if (ci < N) acc += int'(row_vec[k]) * int'(mat_b_out[k][ci]);
        eng_pend = 1'b1;
        eng_cnt  = eng_delay;
        eng_val  = acc;
      end
    end
  end

  // Monitor: counts request pulses, pops the scoreboard on every res_valid.
  always @(negedge clk) begin
    if (enable_product) en_cnt++;
    if (res_valid) begin
      if (sb.size() == 0) begin
        chk("res_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_row", res_row, e.row);
        chk("res_col", res_col, e.col);
        chk("res_data", res_data, e.data);
      end
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(posedge clk); @(negedge clk); n++;
    end
    if (n >= 200) chk({tag, "_idle_timeout"}, n, 0);
  endtask

  task automatic load_inputs();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        mat_a[i][j] = ma[i][j];
        mat_b[i][j] = mb[i][j];
      end
  endtask

  task automatic push_expected();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        sb.push_back('{row: i, col: j, data: ref_c(i, j)});
  endtask

  task automatic run_mult(input string tag);
    int cyc, exp_lat, bad;
    int ec [0:N-1][0:N-1];
    wait_idle(tag);
    load_inputs();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        ec[i][j] = eng_mute ? 0 : ref_c(i, j);
    if (!eng_mute) push_expected();
    en_cnt = 0;
    start  = 1'b1;
    cyc    = 0;
    do begin
      @(posedge clk); cyc++; @(negedge clk);
      start = 1'b0;
      if (cyc == 1) begin
        chk({tag, "_busy_after_start"}, busy, 1);
        chk({tag, "_err_cleared"}, err, 0);
      end
    end while (done !== 1'b1 && cyc < 4000);
    exp_lat = eng_mute ? TIMEOUT + 2 : N * N * (eng_delay + 1) + 1;
    chk({tag, "_done_cycle"}, cyc, exp_lat);
    chk({tag, "_err_at_done"}, err, eng_mute);
    chk({tag, "_enable_pulses"}, en_cnt, eng_mute ? 1 : N * N);
    @(posedge clk); @(negedge clk);
    chk({tag, "_done_single"}, done, 0);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_err_sticky"}, err, eng_mute);
    chk({tag, "_sb_drained"}, sb.size(), 0);
    bad = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (mat_c[i][j] !== ec[i][j]) bad++;
    chk({tag, "_mat_c_bad"}, bad, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = $urandom;
        mb[i][j] = $urandom;
      end
  endtask

  initial begin
    int bad, dn, bl;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 0;
        mb[i][j] = 0;
      end
    load_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);

    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (row_vec[i] !== 0) bad++;
      for (int j = 0; j < N; j++) begin
        if (mat_c[i][j] !== 0) bad++;
        if (mat_b_out[i][j] !== 0) bad++;
      end
    end
    chk("reset_arrays_nonzero", bad, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_enable", enable_product, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_column_index", column_index, 0);
    reset = 1'b0;

    // Basic multiply
    ma = '{'{1, 2}, '{3, 4}};
    mb = '{'{5, 6}, '{7, 8}};
    eng_delay = 1;
    run_mult("basic");

    // Signed values and 32-bit wrap
    ma = '{'{-3, 2}, '{0, 1}};
    mb = '{'{4, -1}, '{2147483647, 2}};
    run_mult("signed");
    ma = '{'{2147483647, 0}, '{0, 0}};
    mb = '{'{2, 0}, '{0, 0}};
    run_mult("wrap");

    // Random operands and engine latencies
    for (int r = 0; r < 6; r++) begin
      fill_random();
      eng_delay = $urandom_range(1, 4);
      run_mult("rand");
    end

    // Slow engine
    fill_random();
    eng_delay = 3;
    run_mult("slow");
    eng_delay = 1;

    // start held high: one run, brief IDLE, one more run; DONE ignores start
    wait_idle("hold");
    fill_random();
    load_inputs();
    push_expected();
    push_expected();
    en_cnt = 0;
    dn = 0;
    bl = 0;
    start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); @(negedge clk);
      if (done === 1'b1) dn++;
      if (busy === 1'b0) bl++;
    end
    start = 1'b0;
    chk("hold_done_pulses", dn, 2);
    chk("hold_idle_cycles", bl, 2);
    chk("hold_enable_pulses", en_cnt, 2 * N * N);
    @(posedge clk); @(negedge clk);
    chk("hold_sb_drained", sb.size(), 0);
    chk("hold_no_third_run", busy, 0);

    // Watchdog timeout, then a normal run clears err
    fill_random();
    eng_mute = 1'b1;
    run_mult("timeout");
    eng_mute = 1'b0;
    fill_random();
    run_mult("after_timeout");

    // Reset in the WAIT of element (0,1)
    wait_idle("rst");
    fill_random();
    load_inputs();
    push_expected();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("rst_wait_column", column_index, 1);
    chk("rst_sb_left", sb.size(), N * N - 1);
    reset = 1'b1;
    sb.delete();
    @(posedge clk); @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_enable", enable_product, 0);
    chk("rst_res_valid", res_valid, 0);
    bad = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (mat_c[i][j] !== 0) bad++;
    chk("rst_mat_c_nonzero", bad, 0);
    reset = 1'b0;
    en_cnt = 0;
    repeat (5) begin @(posedge clk); @(negedge clk); end
    chk("rst_quiet_enables", en_cnt, 0);
    chk("rst_quiet_busy", busy, 0);
    fill_random();
    run_mult("after_reset");

    chk("final_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
